// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - key codes, frame/scanner enums and key code builder for the keypad scanner
package key_pkg;

  localparam logic [4:0] KEY_NONE   = 5'h00;
  localparam logic [4:0] KEY_NEXT   = 5'h1e;
  localparam logic [4:0] KEY_SELECT = 5'h1d;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_DB,
    ST_HELD,
    ST_REL_DB
  } scan_state_e;

  typedef enum logic [1:0] {
    FR_NONE,
    FR_SINGLE,
    FR_MULTI
  } frame_kind_e;

  function automatic logic [4:0] key_code(input logic [1:0] row, input logic [1:0] col);
    return {1'b1, row, col};
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// rtl/keypad_scan_if.sv - keypad matrix pins and key event outputs of the scanner
interface keypad_scan_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [4:0] key;
  logic [4:0] key_pulse;

  modport master (input row_in, output col_out, output key, output key_pulse);
  modport slave  (output row_in, input col_out, input key, input key_pulse);
endinterface

// File: rtl/key_frame_eval.sv
// rtl/key_frame_eval.sv - classifies a 16-bit frame as NONE/SINGLE/MULTI and encodes the key
module key_frame_eval
  import key_pkg::*;
(
  input  logic [15:0]  frame_i,
  output frame_kind_e  kind_o,
  output logic [4:0]   code_o
);

  logic [4:0] hits;
  logic [4:0] last_code;

  // Frame bit index is {row, col}, so the bit position maps straight onto the code.
  always_comb begin
    hits      = 5'd0;
    last_code = KEY_NONE;
    for (int i = 0; i < 16; i++) begin
      if (frame_i[i]) begin
        hits      = hits + 5'd1;
        last_code = key_code(2'(i >> 2), 2'(i));
      end
    end
    kind_o = FR_NONE;
    code_o = KEY_NONE;
    if (hits == 5'd1) begin
      kind_o = FR_SINGLE;
      code_o = last_code;
    end else if (hits > 5'd1) begin
      kind_o = FR_MULTI;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 keypad column scanner and debouncer; KEY_REPEAT_EN adds auto-repeat
module keypad_scan
  import key_pkg::*;
#(
  parameter int SCAN_DIV = 2500,
  parameter int DEBOUNCE = 4
) (
  input logic           clk,
  input logic           rst,
  keypad_scan_if.master kp
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE);

  logic [3:0]    row_s1_q, row_s2_q;
  logic [SW-1:0] slot_q;
  logic [3:0]    col_q;
  logic [1:0]    col_idx_q;
  logic [15:0]   frame_q, frame_d;
  scan_state_e   state_q, state_d;
  logic [4:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    key_q, key_d;
  logic [4:0]    pulse_q, pulse_d;
`ifdef KEY_REPEAT_EN
  logic [5:0]    rep_q, rep_d;
`endif

  frame_kind_e   kind;
  logic [4:0]    code;
  logic          slot_tc, frame_end;

  assign slot_tc   = (slot_q == SLOT_LAST);
  assign frame_end = slot_tc && (col_idx_q == 2'd3);

  // Evaluate the frame including the col3 sample landing this cycle.
  always_comb begin
    frame_d = frame_q;
    if (slot_tc) begin
      for (int r = 0; r < 4; r++) begin
        frame_d[{2'(r), col_idx_q}] = ~row_s2_q[r];
      end
    end
  end

  key_frame_eval u_eval (
    .frame_i (frame_d),
    .kind_o  (kind),
    .code_o  (code)
  );

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    pulse_d = KEY_NONE;
`ifdef KEY_REPEAT_EN
    rep_d   = (state_q == ST_HELD) ? rep_q : 6'd0;
`endif
    if (frame_end) begin
      case (state_q)
        ST_IDLE: begin
          if (kind == FR_SINGLE) begin
            if (DEBOUNCE == 1) begin
              state_d = ST_HELD;
              key_d   = code;
              pulse_d = code;
              cnt_d   = '0;
            end else begin
              state_d = ST_PRESS_DB;
              cand_d  = code;
              cnt_d   = CW'(1);
            end
          end
        end
        ST_PRESS_DB: begin
          if (kind == FR_SINGLE && code == cand_q) begin
            if (cnt_q + 1'b1 == DB_LAST) begin
              state_d = ST_HELD;
              key_d   = cand_q;
              pulse_d = cand_q;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (kind == FR_SINGLE) begin
            cand_d = code;
            cnt_d  = CW'(1);
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_HELD: begin
          if (kind == FR_NONE) begin
            if (DEBOUNCE == 1) begin
              state_d = ST_IDLE;
              key_d   = KEY_NONE;
              cnt_d   = '0;
            end else begin
              state_d = ST_REL_DB;
              cnt_d   = CW'(1);
            end
          end else begin
`ifdef KEY_REPEAT_EN
            // First repeat after 32 held frames, then every 8.
            if (rep_q == 6'd31) begin
              pulse_d = key_q;
              rep_d   = 6'd24;
            end else begin
              rep_d = rep_q + 6'd1;
            end
`endif
          end
        end
        ST_REL_DB: begin
          if (kind == FR_NONE) begin
            if (cnt_q + 1'b1 == DB_LAST) begin
              state_d = ST_IDLE;
              key_d   = KEY_NONE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            state_d = ST_HELD;
            cnt_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_s1_q  <= 4'hF;
      row_s2_q  <= 4'hF;
      slot_q    <= '0;
      col_q     <= 4'b1110;
      col_idx_q <= 2'd0;
      frame_q   <= 16'h0000;
      state_q   <= ST_IDLE;
      cand_q    <= KEY_NONE;
      cnt_q     <= '0;
      key_q     <= KEY_NONE;
      pulse_q   <= KEY_NONE;
`ifdef KEY_REPEAT_EN
      rep_q     <= 6'd0;
`endif
    end else begin
      row_s1_q <= kp.row_in;
      row_s2_q <= row_s1_q;
      frame_q  <= frame_d;
      if (slot_tc) begin
        slot_q    <= '0;
        col_q     <= {col_q[2:0], col_q[3]};
        col_idx_q <= col_idx_q + 2'd1;
      end else begin
        slot_q <= slot_q + 1'b1;
      end
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      pulse_q <= pulse_d;
`ifdef KEY_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign kp.col_out   = col_q;
  assign kp.key       = key_q;
  assign kp.key_pulse = pulse_q;

endmodule
